sd_host_cmd_fsm: RTL and testbench
==================================

// Module: sd_host_cmd_fsm
// PURPOSE
//  Host-side SD CMD-line initiator: serialises a 48-bit command frame (start, transmit, index,
//  argument, CRC7, end) onto CMD, then waits for and captures the card's response (48 or 136 bit).
//  Pairs with the SD slave card model; one instance per host port, driven by the host controller.
// PARAMETERS
//  NCR_MAX  64  max clk samples between command end bit and response start bit before timeout
//  NCC      8   idle clocks (cmd_oe=0) after transaction before done asserts
// PORTS
//  clk       in   1    SD clock; CMD bits change/sampled on rising edge
//  rst       in   1    asynchronous, active-high reset
//  start     in   1    request pulse; accepted only when busy==0
//  cmd_idx   in   6    command index, sampled at accept
//  cmd_arg   in   32   command argument, sampled at accept
//  rsp_type  in   2    0 none, 1 48-bit with CRC (R1/R6/R7), 2 136-bit (R2), 3 48-bit no CRC (R3)
//  cmd_i     in   1    CMD line input (pulled up, 1 when idle)
//  cmd_o     out  1    CMD line drive value
//  cmd_oe    out  1    CMD line output enable
//  busy      out  1    transaction in progress
//  done      out  1    one-cycle completion pulse
//  timeout   out  1    no response start bit within NCR_MAX samples
//  crc_err   out  1    response CRC7 mismatch (rsp_type 1 only)
//  rsp       out  128  captured response, bits after start+transmit bits, right-aligned
// BEHAVIOUR
//  Reset: cmd_o=1, cmd_oe=0, busy=0, done=0, timeout=0, crc_err=0, rsp=0, state IDLE.
//  States: IDLE -> TX -> (WAIT -> RX ->) NCC -> IDLE. Encoding in shared defines.
//  IDLE: start&&!busy in cycle N -> latch idx/arg/type, clear timeout/crc_err/rsp, busy=1 from N+1.
//  TX: cmd_oe=1 cycles N+1..N+48; frame bit k (47..0) on cmd_o at cycle N+1+(47-k), MSB first.
//   Frame = {1'b0,1'b1,idx,arg,crc7,1'b1}; crc7 poly x^7+x^3+1, init 0, over frame bits 47..8.
//   After end bit cmd_oe=0; rsp_type 0 -> NCC, else -> WAIT.
//  WAIT: sample cmd_i each clk; first 0 = response start bit -> RX. Counter counts samples;
//   NCR_MAX samples without 0 -> timeout=1, -> NCC.
//  RX: shift cmd_i MSB first into rsp; 47 further bits (type 1/3) or 135 (type 2).
//   48-bit: rsp[45:0] = frame bits 45..0, rsp[127:46]=0. 136-bit: rsp[127:0] = frame bits 127..0.
//   Type 1: CRC7 over received bits 47..8 compared to bits 7..1; mismatch -> crc_err=1.
//   End bit value not checked. Last bit -> NCC.
//  NCC: cmd_oe=0 for NCC clks; then done=1 for 1 cycle, busy=0 same cycle, -> IDLE.
//  timeout/crc_err/rsp hold until next accepted start. start while busy ignored (no queue).
//  start in the done cycle is accepted (busy already 0). Reset mid-transaction -> reset values,
//  IDLE immediately; no partial frame completion.
// CONFIGURATION
//  SD_HOST_CMD_RSP_CRC_EN defined: type-1 response CRC check as above.
//  Undefined: no RX CRC logic; crc_err tied 0; type 1 behaves as type 3. TX CRC always present.
// STRUCTURE
//  Shared include sd_host_defines.v: rsp_type codes, state encodings, NCR/NCC defaults.
//  Sub-module sd_crc7: serial CRC7 LFSR (clr, en, bit_in, crc[6:0]); one instance for TX,
//   second instance for RX under SD_HOST_CMD_RSP_CRC_EN.
// TESTING
//  CMD0 arg 0, type 0 -> cmd_o 0x400000000095 over 48 clks, 8 idle clks, done, timeout=0.
//  CMD8 arg 0x1AA type 1, card returns 0x08000001AA13 after 5 clks -> rsp=0x08000001AA13 bits
//   45..0, crc_err=0; flip one arg bit in response -> crc_err=1 (macro on), 0 (macro off).
//  CMD55 arg 0 -> frame 0x770000000065; CMD line held 1 -> timeout=1 after 64 samples, done pulse.
//  CMD2 type 2, card sends 136-bit R2 -> rsp[127:0] equals sent bits 127..0, crc_err=0.
//  start pulsed while busy -> ignored, frame unchanged; start in done cycle -> new TX next cycle.
//  rst asserted at TX bit 20 -> cmd_oe=0, cmd_o=1, busy=0 same cycle; next start sends full frame.

Source files
------------

// File: rtl/sd_host_cmd_fsm_pkg.sv
// Shared types for the SD host CMD-line initiator:
// FSM state encoding, response type codes and timing defaults.
package sd_host_cmd_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_WAIT = 3'd2,
    ST_RX   = 3'd3,
    ST_NCC  = 3'd4
  } state_t;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_R1   = 2'd1;
  localparam logic [1:0] RSP_R2   = 2'd2;
  localparam logic [1:0] RSP_R3   = 2'd3;

  localparam int NCR_MAX_DEF = 64;
  localparam int NCC_DEF     = 8;

endpackage

// File: rtl/sd_host_cmd_fsm_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per enabled clock.
// Ports: clk, rst (async high), clr, en, bit_in -> crc[6:0].
module sd_host_cmd_fsm_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_host_cmd_fsm.sv
// SD host CMD-line initiator: sends a 48-bit command frame, then
// captures a 48/136-bit response or flags a timeout.
// Ports: clk, rst (async high), start, cmd_idx, cmd_arg, rsp_type,
//  cmd_i -> cmd_o, cmd_oe, busy, done, timeout, crc_err, rsp[127:0].
// Define SD_HOST_CMD_RSP_CRC_EN to check CRC7 on type-1 responses.
module sd_host_cmd_fsm
  import sd_host_cmd_fsm_pkg::*;
#(
  parameter int NCR_MAX = NCR_MAX_DEF,
  parameter int NCC     = NCC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_idx,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   rsp_type,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [127:0] rsp
);

  state_t      state, state_d;
  logic [7:0]  cnt;
  logic [39:0] tx_sr;
  logic [1:0]  typ;
  logic [6:0]  tx_crc;
  logic [2:0]  crc_sel;
  logic        accept;
  logic        tx_crc_en;
  logic        rx_last;

  assign busy      = (state != ST_IDLE);
  assign accept    = (state == ST_IDLE) && start;
  assign tx_crc_en = (state == ST_TX) && (cnt < 8'd40);
  // frame bits 7..1 come from crc[6..0] at cnt 40..46
  assign crc_sel   = 3'(8'd46 - cnt);

  sd_host_cmd_fsm_crc7 u_tx_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (tx_crc_en),
    .bit_in (tx_sr[39]),
    .crc    (tx_crc)
  );

`ifdef SD_HOST_CMD_RSP_CRC_EN
  logic [6:0] rx_crc;
  logic       rx_crc_en;

  // start bit is 0 and leaves a zero CRC unchanged,
  // so accumulation begins at the transmission bit
  assign rx_crc_en = (state == ST_RX) && (cnt < 8'd39);

  sd_host_cmd_fsm_crc7 u_rx_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (rx_crc_en),
    .bit_in (cmd_i),
    .crc    (rx_crc)
  );
`endif

  // cnt in RX indexes bits after the start bit
  always_comb begin
    rx_last = 1'b0;
    unique case (typ)
      RSP_R2:         rx_last = (cnt == 8'd134);
      RSP_R1, RSP_R3: rx_last = (cnt == 8'd46);
      default:        rx_last = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    cmd_o   = 1'b1;
    cmd_oe  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        cmd_oe = 1'b1;
        if (cnt < 8'd40) begin
          cmd_o = tx_sr[39];
        end else if (cnt < 8'd47) begin
          cmd_o = tx_crc[crc_sel];
        end
        if (cnt == 8'd47) begin
          state_d = (typ == RSP_NONE) ? ST_NCC : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cmd_i) begin
          state_d = ST_RX;
        end else if (cnt == 8'(NCR_MAX - 1)) begin
          state_d = ST_NCC;
        end
      end
      ST_RX: begin
        if (rx_last) begin
          state_d = ST_NCC;
        end
      end
      ST_NCC: begin
        if (cnt == 8'(NCC - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tx_sr   <= '0;
      typ     <= RSP_NONE;
      done    <= 1'b0;
      timeout <= 1'b0;
      crc_err <= 1'b0;
      rsp     <= '0;
    end else begin
      done <= 1'b0;
      if (state_d != state) begin
        cnt <= '0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + 8'd1;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr   <= {2'b01, cmd_idx, cmd_arg};
            typ     <= rsp_type;
            timeout <= 1'b0;
            crc_err <= 1'b0;
            rsp     <= '0;
          end
        end
        ST_TX: begin
          tx_sr <= {tx_sr[38:0], 1'b0};
        end
        ST_WAIT: begin
          if (state_d == ST_NCC) begin
            timeout <= 1'b1;
          end
        end
        ST_RX: begin
          // transmission bit is dropped; rsp holds what follows
          if (cnt != 8'd0) begin
            rsp <= {rsp[126:0], cmd_i};
          end
`ifdef SD_HOST_CMD_RSP_CRC_EN
          // on the end bit, rsp[6:0] holds received bits 7..1
          if (rx_last && typ == RSP_R1) begin
            crc_err <= (rsp[6:0] != rx_crc);
          end
`endif
        end
        ST_NCC: begin
          if (state_d == ST_IDLE) begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host_cmd_fsm.sv
// Testbench for sd_host_cmd_fsm: vector table plus corner sequences,
// with frame and result scoreboards fed at start and drained at output.
module tb_sd_host_cmd_fsm;

`ifdef SD_HOST_CMD_RSP_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   cmd_idx = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   rsp_type = '0;
  logic         cmd_i = 1'b1;
  logic         cmd_o, cmd_oe, busy, done, timeout, crc_err;
  logic [127:0] rsp;

  sd_host_cmd_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd_idx  (cmd_idx),
    .cmd_arg  (cmd_arg),
    .rsp_type (rsp_type),
    .cmd_i    (cmd_i),
    .cmd_o    (cmd_o),
    .cmd_oe   (cmd_oe),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .crc_err  (crc_err),
    .rsp      (rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    logic [47:0]  frame;
    int           nbits;
    int           dly;
    logic [135:0] rbits;
    logic         tmo;
    logic         cerr;
    logic [127:0] rsp;
    int           lat;
  } vec_t;

  typedef struct {
    logic         tmo;
    logic         cerr;
    logic [127:0] rsp;
  } res_t;

  logic [47:0] frame_q[$];
  res_t        res_q[$];
  vec_t        tv[7];
  int          nchk = 0;
  int          nerr = 0;
  logic [47:0] cap = '0;
  int          cap_n = 0;

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // long division by x^7+x^3+1 over the 40 message bits
  function automatic logic [6:0] crc7f(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] i,
                                          input logic [31:0] a);
    return {2'b01, i, a, crc7f({2'b01, i, a}), 1'b1};
  endfunction

  function automatic vec_t mkv(
    input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
    input logic [47:0] f, input int nb, input int d,
    input logic [135:0] rb, input logic tm, input logic ce,
    input logic [127:0] r, input int l);
    vec_t v;
    v.idx = i; v.arg = a; v.rt = t; v.frame = f;
    v.nbits = nb; v.dly = d; v.rbits = rb;
    v.tmo = tm; v.cerr = ce; v.rsp = r; v.lat = l;
    return v;
  endfunction

  // frame scoreboard: collect CMD bits while driven
  always @(negedge clk) begin
    if (rst) begin
      cap_n = 0;
    end else if (cmd_oe) begin
      cap = {cap[46:0], cmd_o};
      cap_n++;
      if (cap_n == 48) begin
        cap_n = 0;
        if (frame_q.size() == 0) begin
          chk("frame_expected", 136'(0), 136'(1));
        end else begin
          chk("frame", 136'(cap), 136'(frame_q.pop_front()));
        end
      end
    end
  end

  // result scoreboard: compare flags and rsp on done
  always @(negedge clk) begin
    res_t r;
    if (!rst && done) begin
      if (res_q.size() == 0) begin
        chk("done_expected", 136'(0), 136'(1));
      end else begin
        r = res_q.pop_front();
        chk("timeout", 136'(timeout), 136'(r.tmo));
        chk("crc_err", 136'(crc_err), 136'(r.cerr));
        chk("rsp", 136'(rsp), 136'(r.rsp));
      end
    end
  end

  task automatic push_exp(input vec_t v);
    res_t r;
    r.tmo = v.tmo; r.cerr = v.cerr; r.rsp = v.rsp;
    frame_q.push_back(v.frame);
    res_q.push_back(r);
  endtask

  task automatic pulse_start(input logic [5:0] i, input logic [31:0] a,
                             input logic [1:0] t);
    @(negedge clk);
    cmd_idx = i; cmd_arg = a; rsp_type = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cmd_oe) begin
        ok = 1'b1;
        break;
      end
    end
    chk("oe_fall_seen", 136'(ok), 136'(1));
  endtask

  task automatic wait_done(output int lat);
    bit ok;
    ok = 1'b0;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        lat = k;
        break;
      end
    end
    chk("done_seen", 136'(ok), 136'(1));
  endtask

  task automatic run_txn(input vec_t v);
    bit ok;
    int got;
    push_exp(v);
    pulse_start(v.idx, v.arg, v.rt);
    wait_fall(ok);
    got = -1;
    if (ok) begin
      for (int k = 1; k <= 400; k++) begin
        @(negedge clk);
        if (done) begin
          got = k;
          break;
        end
        if (k >= v.dly && k < v.dly + v.nbits) begin
          cmd_i = v.rbits[v.nbits - 1 - (k - v.dly)];
        end else begin
          cmd_i = 1'b1;
        end
      end
      chk("latency", 136'(got), 136'(v.lat));
      chk("busy_at_done", 136'(busy), 136'(0));
    end
    cmd_i = 1'b1;
  endtask

  initial begin
    logic [31:0]  stat;
    logic [31:0]  rarg;
    logic [39:0]  r1;
    logic [127:0] cid;
    logic [47:0]  r1f;
    int           lat;
    bit           extra;

    stat = $urandom;
    rarg = $urandom;
    r1   = {2'b00, 6'd17, stat};
    r1f  = {r1, crc7f(r1), 1'b1};
    cid  = 128'h0123456789ABCDEF_FEDCBA9876543211;

    tv[0] = mkv(6'd0, 32'h0, 2'd0, 48'h400000000095, 0, 0,
                '0, 1'b0, 1'b0, '0, 8);
    tv[1] = mkv(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 48, 5,
                136'(48'h08000001AA13), 1'b0, 1'b0,
                128'(48'h08000001AA13), 61);
    tv[2] = mkv(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 48, 5,
                136'(48'h08000001AB13), 1'b0, CRC_ON,
                128'(48'h08000001AB13), 61);
    tv[3] = mkv(6'd55, 32'h0, 2'd1, 48'h770000000065, 0, 0,
                '0, 1'b1, 1'b0, '0, 72);
    tv[4] = mkv(6'd2, 32'h0, 2'd2, 48'h42000000004D, 136, 5,
                {8'h3F, cid}, 1'b0, 1'b0, cid, 149);
    tv[5] = mkv(6'd41, 32'h40300000, 2'd3, mkframe(6'd41, 32'h40300000),
                48, 5, 136'(48'h3F00FF8000FF), 1'b0, 1'b0,
                128'(48'h3F00FF8000FF), 61);
    tv[6] = mkv(6'd17, rarg, 2'd1, mkframe(6'd17, rarg), 48, 3,
                136'(r1f), 1'b0, 1'b0, 128'(r1f), 59);

    #12;
    chk("rst_cmd_o", 136'(cmd_o), 136'(1));
    chk("rst_cmd_oe", 136'(cmd_oe), 136'(0));
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_done", 136'(done), 136'(0));
    chk("rst_timeout", 136'(timeout), 136'(0));
    chk("rst_crc_err", 136'(crc_err), 136'(0));
    chk("rst_rsp", 136'(rsp), 136'(0));
    #10 rst = 1'b0;

    for (int n = 0; n < 7; n++) begin
      run_txn(tv[n]);
      repeat (3) @(negedge clk);
      chk("flags_hold", 136'({timeout, crc_err}),
          136'({tv[n].tmo, tv[n].cerr}));
      chk("rsp_hold", 136'(rsp), 136'(tv[n].rsp));
    end

    // start while busy must not disturb or queue
    push_exp(tv[0]);
    pulse_start(6'd0, 32'h0, 2'd0);
    repeat (10) @(negedge clk);
    cmd_idx = 6'h2A; cmd_arg = '1; rsp_type = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_tx", 136'(busy), 136'(1));
    wait_done(lat);
    extra = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (cmd_oe) extra = 1'b1;
    end
    chk("no_extra_tx", 136'(extra), 136'(0));
    chk("frames_drained", 136'(frame_q.size()), 136'(0));

    // start in the done cycle launches the next frame at once
    push_exp(tv[0]);
    push_exp(mkv(6'd55, 32'h0, 2'd0, 48'h770000000065, 0, 0,
                 '0, 1'b0, 1'b0, '0, 8));
    pulse_start(6'd0, 32'h0, 2'd0);
    wait_done(lat);
    cmd_idx = 6'd55; cmd_arg = '0; rsp_type = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("tx_after_done", 136'({cmd_oe, busy}), 136'(2'b11));
    wait_done(lat);

    // reset in the middle of the command frame
    push_exp(tv[1]);
    pulse_start(tv[1].idx, tv[1].arg, tv[1].rt);
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_oe", 136'(cmd_oe), 136'(0));
    chk("mid_rst_o", 136'(cmd_o), 136'(1));
    chk("mid_rst_busy", 136'(busy), 136'(0));
    void'(frame_q.pop_front());
    void'(res_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    run_txn(tv[1]);
    repeat (5) @(negedge clk);
    chk("queues_empty", 136'(frame_q.size() + res_q.size()), 136'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
